// File: rtl/xy_vector_sequencer_if.sv
// Bus interface for xy_vector_sequencer.
//   start/x_in/y_in            : run request and signed Q16.16 operands
//   busy/done                  : run status and one-cycle completion pulse
//   stage_valid/z_init/y_stage/
//   lookup_table_amount        : per-iteration feed for a downstream angle stage
//   x_out/quad_flip            : final magnitude and 180-degree pre-rotation flag
// master = requester side, slave = sequencer side.
interface xy_vector_sequencer_if;
    localparam int unsigned DATA_W = 32;

    logic              start;
    logic [DATA_W-1:0] x_in;
    logic [DATA_W-1:0] y_in;
    logic              busy;
    logic              stage_valid;
    logic              z_init;
    logic [DATA_W-1:0] y_stage;
    logic [DATA_W-1:0] lookup_table_amount;
    logic [DATA_W-1:0] x_out;
    logic              quad_flip;
    logic              done;

    modport master (
        output start, x_in, y_in,
        input  busy, stage_valid, z_init, y_stage, lookup_table_amount,
               x_out, quad_flip, done
    );

    modport slave (
        input  start, x_in, y_in,
        output busy, stage_valid, z_init, y_stage, lookup_table_amount,
               x_out, quad_flip, done
    );
endinterface

// File: rtl/xy_vector_sequencer.sv
// xy_vector_sequencer: 16-iteration CORDIC vectoring sequencer (Q16.16).
// Drives y to zero while accumulating magnitude in x. Each RUN cycle it
// presents the pre-update y and atan(2^-i) so a registered downstream angle
// stage can track the rotation direction.
// Ports:
//   clock  : rising-edge clock
//   reset  : synchronous active-high reset
//   bus    : xy_vector_sequencer_if.slave (start, operands, stage feed, results)
// Optional build macro CORDIC_GAIN_COMP_EN adds a SCALE cycle that multiplies
// the final x by K=0.607253; without it x_out carries the raw CORDIC gain.
module xy_vector_sequencer (
    input  logic                  clock,
    input  logic                  reset,
    xy_vector_sequencer_if.slave  bus
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ITER_N = 16;
    localparam int unsigned ITER_W = 4;

`ifdef CORDIC_GAIN_COMP_EN
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2, SCALE = 2'd3} state_t;
    localparam logic signed [63:0] K_GAIN = 64'sh0000_0000_0000_9B75;
    logic signed [63:0] x_ext;
    logic signed [63:0] prod;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
`endif

    state_t state_q, state_d;
    logic [ITER_W-1:0]        iter_q, iter_d;
    logic signed [DATA_W-1:0] x_q, x_d, y_q, y_d;
    logic signed [DATA_W-1:0] x_shr, y_shr;
    logic [DATA_W-1:0]        xout_q, xout_d;
    logic                     flip_q, flip_d;
    logic                     busy_q, busy_d;
    logic                     sv_q, sv_d;
    logic                     zi_q, zi_d;
    logic                     done_q, done_d;
    logic [DATA_W-1:0]        ystage_q, ystage_d;
    logic [DATA_W-1:0]        lut_q, lut_d;

    // atan(2^-i) in degrees, Q16.16
    function automatic logic [DATA_W-1:0] atan_lut(input logic [ITER_W-1:0] i);
        case (i)
            4'd0:    atan_lut = 32'h002D_0000;
            4'd1:    atan_lut = 32'h001A_90A8;
            4'd2:    atan_lut = 32'h000E_0947;
            4'd3:    atan_lut = 32'h0007_2001;
            4'd4:    atan_lut = 32'h0003_938B;
            4'd5:    atan_lut = 32'h0001_CA38;
            4'd6:    atan_lut = 32'h0000_E52A;
            4'd7:    atan_lut = 32'h0000_7297;
            4'd8:    atan_lut = 32'h0000_394C;
            4'd9:    atan_lut = 32'h0000_1CA6;
            4'd10:   atan_lut = 32'h0000_0E53;
            4'd11:   atan_lut = 32'h0000_0729;
            4'd12:   atan_lut = 32'h0000_0395;
            4'd13:   atan_lut = 32'h0000_01CA;
            4'd14:   atan_lut = 32'h0000_00E5;
            default: atan_lut = 32'h0000_0073;
        endcase
    endfunction

    // Next-state, datapath and registered-output next values
    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        x_d     = x_q;
        y_d     = y_q;
        xout_d  = xout_q;
        flip_d  = flip_q;
        x_shr   = x_q >>> iter_q;
        y_shr   = y_q >>> iter_q;
`ifdef CORDIC_GAIN_COMP_EN
        x_ext   = {{32{x_q[DATA_W-1]}}, x_q};
        prod    = x_ext * K_GAIN;
`endif

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    // Left half-plane operands are rotated 180 deg so CORDIC converges
                    flip_d  = bus.x_in[DATA_W-1];
                    x_d     = bus.x_in[DATA_W-1] ? -$signed(bus.x_in) : $signed(bus.x_in);
                    y_d     = bus.x_in[DATA_W-1] ? -$signed(bus.y_in) : $signed(bus.y_in);
                    iter_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (y_q[DATA_W-1]) begin
                    y_d = y_q + x_shr;
                    x_d = x_q - y_shr;
                end else begin
                    y_d = y_q - x_shr;
                    x_d = x_q + y_shr;
                end
                iter_d = iter_q + ITER_W'(1);
                if (iter_q == ITER_W'(ITER_N - 1)) begin
`ifdef CORDIC_GAIN_COMP_EN
                    state_d = SCALE;
`else
                    xout_d  = x_d;
                    state_d = DONE;
`endif
                end
            end
`ifdef CORDIC_GAIN_COMP_EN
            SCALE: begin
                xout_d  = 32'(prod >>> 16);
                state_d = DONE;
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered from next-state values so they align with the state
        busy_d   = (state_d != IDLE);
        sv_d     = (state_d == RUN);
        zi_d     = (state_d == RUN) && (iter_d == '0);
        done_d   = (state_d == DONE);
        ystage_d = (state_d == RUN) ? y_d : '0;
        lut_d    = (state_d == RUN) ? atan_lut(iter_d) : '0;
    end

    // State and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            iter_q   <= '0;
            x_q      <= '0;
            y_q      <= '0;
            xout_q   <= '0;
            flip_q   <= 1'b0;
            busy_q   <= 1'b0;
            sv_q     <= 1'b0;
            zi_q     <= 1'b0;
            done_q   <= 1'b0;
            ystage_q <= '0;
            lut_q    <= '0;
        end else begin
            state_q  <= state_d;
            iter_q   <= iter_d;
            x_q      <= x_d;
            y_q      <= y_d;
            xout_q   <= xout_d;
            flip_q   <= flip_d;
            busy_q   <= busy_d;
            sv_q     <= sv_d;
            zi_q     <= zi_d;
            done_q   <= done_d;
            ystage_q <= ystage_d;
            lut_q    <= lut_d;
        end
    end

    assign bus.busy                = busy_q;
    assign bus.stage_valid         = sv_q;
    assign bus.z_init              = zi_q;
    assign bus.y_stage             = ystage_q;
    assign bus.lookup_table_amount = lut_q;
    assign bus.x_out               = xout_q;
    assign bus.quad_flip           = flip_q;
    assign bus.done                = done_q;
endmodule

// File: tb/tb_xy_vector_sequencer.sv
// Directed testbench for xy_vector_sequencer with a registered downstream
// angle stage fed from stage_valid/z_init/y_stage/lookup_table_amount.
module tb_xy_vector_sequencer;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    xy_vector_sequencer_if bus();

    xy_vector_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

`ifdef CORDIC_GAIN_COMP_EN
    localparam logic [31:0] EXP_X1   = 32'h0001_0000;
    localparam logic [31:0] EXP_X2   = 32'h0001_6A0A;
    localparam int          DONE_LAT = 2;
`else
    localparam logic [31:0] EXP_X1   = 32'h0001_A592;
    localparam logic [31:0] EXP_X2   = 32'h0002_5433;
    localparam int          DONE_LAT = 1;
`endif
    localparam logic [31:0] ONE      = 32'h0001_0000;
    localparam logic [31:0] NEG_ONE  = 32'hFFFF_0000;
    localparam logic [31:0] DEG45    = 32'h002D_0000;
    localparam logic [31:0] DEGM45   = 32'hFFD3_0000;

    int n_cmp = 0;
    int n_bad = 0;

    // Downstream angle accumulator, one registered stage
    logic [31:0] angle;
    always @(posedge clock) begin
        if (reset)
            angle <= '0;
        else if (bus.stage_valid)
            angle <= bus.y_stage[31]
                ? ((bus.z_init ? 32'h0 : angle) - bus.lookup_table_amount)
                : ((bus.z_init ? 32'h0 : angle) + bus.lookup_table_amount);
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_tol(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp, input int tol);
        logic signed [31:0] diff;
        logic ok;
        diff = $signed(obs - exp);
        ok = (diff <= tol) && (diff >= -tol);
        n_cmp++;
        assert (ok === 1'b1) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h +/-%0d", tag, obs, exp, tol);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"},  32'(bus.busy), 32'h0);
        check({tag, "_sv"},    32'(bus.stage_valid), 32'h0);
        check({tag, "_zi"},    32'(bus.z_init), 32'h0);
        check({tag, "_ystg"},  bus.y_stage, 32'h0);
        check({tag, "_lut"},   bus.lookup_table_amount, 32'h0);
        check({tag, "_xout"},  bus.x_out, 32'h0);
        check({tag, "_flip"},  32'(bus.quad_flip), 32'h0);
        check({tag, "_done"},  32'(bus.done), 32'h0);
    endtask

    // One vectoring run; optional start poke at RUN cycle poke_at and
    // start held through the DONE cycle when chain is set.
    task automatic run_vector(input string tag, input logic [31:0] xi, input logic [31:0] yi,
                              input logic [31:0] exp_y0, input logic [31:0] exp_x,
                              input logic exp_flip, input logic [31:0] exp_ang,
                              input int poke_at, input bit chain);
        int sv_cnt  = 0;
        int zi_cnt  = 0;
        int last_sv = -1;
        int done_at = -1;
        bus.start = 1'b1;
        bus.x_in  = xi;
        bus.y_in  = yi;
        tick;
        bus.start = 1'b0;
        check({tag, "_y0"},  bus.y_stage, exp_y0);
        check({tag, "_lut0"}, bus.lookup_table_amount, DEG45);
        check({tag, "_flip"}, 32'(bus.quad_flip), 32'(exp_flip));
        for (int cyc = 0; cyc < 40 && done_at < 0; cyc++) begin
            if (bus.stage_valid) begin
                sv_cnt++;
                last_sv = cyc;
            end
            if (bus.z_init) zi_cnt++;
            if (bus.done) begin
                done_at = cyc;
            end else begin
                bus.start = (cyc == poke_at);
                bus.x_in  = (cyc == poke_at) ? 32'h7FFF_0000 : xi;
                bus.y_in  = (cyc == poke_at) ? 32'h1234_0000 : yi;
                tick;
            end
        end
        bus.start = 1'b0;
        check({tag, "_done_at"}, 32'(done_at), 32'(15 + DONE_LAT));
        check({tag, "_sv_cnt"},  32'(sv_cnt), 32'd16);
        check({tag, "_last_sv"}, 32'(last_sv), 32'd15);
        check({tag, "_zi_cnt"},  32'(zi_cnt), 32'd1);
        check({tag, "_busy_dn"}, 32'(bus.busy), 32'h1);
        check({tag, "_sv_dn"},   32'(bus.stage_valid), 32'h0);
        check_tol({tag, "_xout"},  bus.x_out, exp_x, 8);
        check_tol({tag, "_angle"}, angle, exp_ang, 300);
        if (chain) begin
            bus.start = 1'b1;
            bus.x_in  = ONE;
            bus.y_in  = ONE;
        end
        tick;
        check({tag, "_done_off"}, 32'(bus.done), 32'h0);
        check({tag, "_busy_off"}, 32'(bus.busy), 32'h0);
        check({tag, "_sv_off"},   32'(bus.stage_valid), 32'h0);
        check({tag, "_ystg_off"}, bus.y_stage, 32'h0);
        check({tag, "_lut_off"},  bus.lookup_table_amount, 32'h0);
        check_tol({tag, "_xout_hold"}, bus.x_out, exp_x, 8);
    endtask

    initial begin
        int done_seen;
        reset     = 1'b1;
        bus.start = 1'b1;
        bus.x_in  = ONE;
        bus.y_in  = '0;
        repeat (3) tick;
        check_idle_zero("rst");
        reset     = 1'b0;
        bus.start = 1'b0;
        tick;
        check("post_rst_busy", 32'(bus.busy), 32'h0);

        run_vector("c1_x1y0",   ONE,     32'h0,   32'h0,   EXP_X1, 1'b0, 32'h0,  -1, 1'b0);
        run_vector("c2_x1y1",   ONE,     ONE,     ONE,     EXP_X2, 1'b0, DEG45,  -1, 1'b0);
        run_vector("c3_xm1y0",  NEG_ONE, 32'h0,   32'h0,   EXP_X1, 1'b1, 32'h0,  -1, 1'b0);
        run_vector("c4_x1ym1",  ONE,     NEG_ONE, NEG_ONE, EXP_X2, 1'b0, DEGM45, -1, 1'b0);
        run_vector("c5_xm1ym1", NEG_ONE, NEG_ONE, ONE,     EXP_X2, 1'b1, DEG45,  -1, 1'b0);

        // Abort at RUN cycle 8 with start held alongside reset
        bus.start = 1'b1;
        bus.x_in  = NEG_ONE;
        bus.y_in  = ONE;
        tick;
        bus.start = 1'b0;
        check("abort_flip_set", 32'(bus.quad_flip), 32'h1);
        repeat (8) tick;
        reset     = 1'b1;
        bus.start = 1'b1;
        tick;
        check_idle_zero("abort");
        reset     = 1'b0;
        bus.start = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 25; k++) begin
            tick;
            if (bus.done) done_seen++;
        end
        check("abort_no_done", 32'(done_seen), 32'h0);
        check("abort_idle_busy", 32'(bus.busy), 32'h0);

        // Start poked mid-run and in DONE is ignored; start in the next IDLE cycle runs
        run_vector("c6_poke",  ONE, 32'h0, 32'h0, EXP_X1, 1'b0, 32'h0, 5, 1'b1);
        run_vector("c7_chain", ONE, ONE,   ONE,   EXP_X2, 1'b0, DEG45, -1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
